// File: rtl/wb_stage.sv
// Writeback stage: retires MEM-stage results into the register file, waiting for load data when needed.
// ALU result writes one cycle after accept; loads write one cycle after rvalid; mem_ready is low while a load is outstanding.
module wb_stage #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic        mem_wr_en,
   input  logic [4:0]  mem_wr_addr,
   input  logic [31:0] mem_alu_result,
   input  logic        mem_is_load,
   input  logic [2:0]  mem_load_type,
   input  logic        flush,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        wr_en,
   output logic [4:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic        wb_busy,
   output logic        load_err,
   output logic        align_err
);

   typedef enum logic {IDLE, WAIT_LOAD} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ld_wen_q, ld_wen_d;
   logic [4:0]  ld_addr_q, ld_addr_d;
   logic [1:0]  ld_off_q, ld_off_d;
   logic [2:0]  ld_type_q, ld_type_d;
   logic        wr_en_q, wr_en_d;
   logic [4:0]  wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        load_err_q, load_err_d;
   logic        align_err_q, align_err_d;

   logic        misaligned;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] ld_val;

   assign mem_ready = (state_q == IDLE) && !reset;

   // Unknown load codes behave as LW, including the alignment rule.
   always_comb begin
      misaligned = 1'b0;
      case (mem_load_type)
         3'b000, 3'b100: misaligned = 1'b0;
         3'b001, 3'b101: misaligned = mem_alu_result[0];
         default:        misaligned = |mem_alu_result[1:0];
      endcase
   end

   always_comb begin
      byte_v = 8'h00;
      case (ld_off_q)
         2'd0: byte_v = dmem_rdata[31:24];
         2'd1: byte_v = dmem_rdata[23:16];
         2'd2: byte_v = dmem_rdata[15:8];
         2'd3: byte_v = dmem_rdata[7:0];
         default: byte_v = 8'h00;
      endcase
      half_v = ld_off_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
      case (ld_type_q)
         3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
         3'b100:  ld_val = {24'h000000, byte_v};
         3'b001:  ld_val = {{16{half_v[15]}}, half_v};
         3'b101:  ld_val = {16'h0000, half_v};
         default: ld_val = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ld_wen_d    = ld_wen_q;
      ld_addr_d   = ld_addr_q;
      ld_off_d    = ld_off_q;
      ld_type_d   = ld_type_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      load_err_d  = 1'b0;
      align_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_valid) begin
               if (!mem_is_load) begin
                  if (mem_wr_en && (mem_wr_addr != 5'd0)) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = mem_wr_addr;
                     wr_data_d = mem_alu_result;
                  end
               end else if (misaligned) begin
                  align_err_d = 1'b1;
               end else begin
                  state_d   = WAIT_LOAD;
                  cnt_d     = 8'd0;
                  ld_wen_d  = mem_wr_en;
                  ld_addr_d = mem_wr_addr;
                  ld_off_d  = mem_alu_result[1:0];
                  ld_type_d = mem_load_type;
               end
            end
         end
         WAIT_LOAD: begin
            // Flush beats data, and data beats the timeout.
            if (flush) begin
               state_d = IDLE;
            end else if (dmem_rvalid) begin
               state_d = IDLE;
               if (ld_wen_q && (ld_addr_q != 5'd0)) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ld_addr_q;
                  wr_data_d = ld_val;
               end
            end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
               state_d    = IDLE;
               load_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         ld_wen_q    <= 1'b0;
         ld_addr_q   <= 5'd0;
         ld_off_q    <= 2'd0;
         ld_type_q   <= 3'd0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= 5'd0;
         wr_data_q   <= 32'd0;
         load_err_q  <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ld_wen_q    <= ld_wen_d;
         ld_addr_q   <= ld_addr_d;
         ld_off_q    <= ld_off_d;
         ld_type_q   <= ld_type_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         load_err_q  <= load_err_d;
         align_err_q <= align_err_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign wb_busy   = (state_q == WAIT_LOAD);
   assign load_err  = load_err_q;
   assign align_err = align_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed test-plan cases with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model that times loads by cycle stamps.
module tb_wb_stage;
   localparam int MW = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_valid = 0, mem_wr_en = 0, mem_is_load = 0, flush = 0, dmem_rvalid = 0;
   logic [4:0]  mem_wr_addr = 0;
   logic [31:0] mem_alu_result = 0, dmem_rdata = 0;
   logic [2:0]  mem_load_type = 0;
   logic        mem_ready, wr_en, wb_busy, load_err, align_err;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   always #5 clk = ~clk;

   wb_stage #(.MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_alu_result(mem_alu_result),
      .mem_is_load(mem_is_load), .mem_load_type(mem_load_type), .flush(flush),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wb_busy(wb_busy), .load_err(load_err), .align_err(align_err)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Model state: one outstanding load, stamped with its accept cycle.
   bit          pend = 0;
   int          start = 0;
   bit          l_wen;
   logic [4:0]  l_addr;
   logic [1:0]  l_off;
   logic [2:0]  l_type;
   logic        e_ready = 0, e_wr_en = 0, e_busy = 0, e_lerr = 0, e_aerr = 0, e_rst = 0;
   logic [4:0]  e_addr = 0;
   logic [31:0] e_data = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic int access_size(input logic [2:0] t);
      if (t == 3'b000 || t == 3'b100) return 1;
      if (t == 3'b001 || t == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] load_value(input logic [2:0] t, input logic [1:0] off,
                                              input logic [31:0] d);
      int          sz;
      logic [31:0] v;
      sz = access_size(t);
      if (sz == 4) return d;
      v = d >> (8 * (4 - sz - int'(off)));
      if (sz == 1) begin
         v = v & 32'h0000_00FF;
         if (!t[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else begin
         v = v & 32'h0000_FFFF;
         if (!t[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   // One clock: check mem_ready, advance the model on the current inputs, then compare registered outputs.
   task automatic step();
      #1;
      e_ready = !reset && !pend;
      chk("mem_ready", {31'd0, mem_ready}, {31'd0, e_ready});
      e_wr_en = 0; e_lerr = 0; e_aerr = 0; e_rst = reset;
      if (reset) begin
         pend = 0; e_addr = 0; e_data = 0;
      end else if (!pend) begin
         if (mem_valid) begin
            if (!mem_is_load) begin
               if (mem_wr_en && mem_wr_addr != 0) begin
                  e_wr_en = 1; e_addr = mem_wr_addr; e_data = mem_alu_result;
               end
            end else if (int'(mem_alu_result[1:0]) % access_size(mem_load_type) != 0) begin
               e_aerr = 1;
            end else begin
               pend = 1; start = cyc;
               l_wen = mem_wr_en; l_addr = mem_wr_addr;
               l_off = mem_alu_result[1:0]; l_type = mem_load_type;
            end
         end
      end else begin
         if (flush) begin
            pend = 0;
         end else if (dmem_rvalid) begin
            pend = 0;
            if (l_wen && l_addr != 0) begin
               e_wr_en = 1; e_addr = l_addr; e_data = load_value(l_type, l_off, dmem_rdata);
            end
         end else if (cyc - start == MW) begin
            pend = 0; e_lerr = 1;
         end
      end
      e_busy = pend;
      @(posedge clk);
      #1;
      cyc++;
      chk("wr_en", {31'd0, wr_en}, {31'd0, e_wr_en});
      chk("wb_busy", {31'd0, wb_busy}, {31'd0, e_busy});
      chk("load_err", {31'd0, load_err}, {31'd0, e_lerr});
      chk("align_err", {31'd0, align_err}, {31'd0, e_aerr});
      if (e_wr_en || e_rst) begin
         chk("wr_addr", {27'd0, wr_addr}, {27'd0, e_addr});
         chk("wr_data", wr_data, e_data);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] a, input logic [31:0] alu,
                        input logic ld, input logic [2:0] lt);
      mem_valid = v; mem_wr_en = we; mem_wr_addr = a; mem_alu_result = alu;
      mem_is_load = ld; mem_load_type = lt;
   endtask

   task automatic rsp(input logic rv, input logic [31:0] d);
      dmem_rvalid = rv; dmem_rdata = d;
   endtask

   int          busy_n;
   logic [2:0]  lt_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

   initial begin
      // Reset
      step(); step();
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_busy", {31'd0, wb_busy}, 32'd0);
      reset = 0;

      // Back-to-back ALU writes
      drive(1, 1, 5'd3, 32'h11, 0, 3'd0); step();
      chk("addu1_en", {31'd0, wr_en}, 32'd1);
      chk("addu1_addr", {27'd0, wr_addr}, 32'd3);
      chk("addu1_data", wr_data, 32'h11);
      drive(1, 1, 5'd4, 32'h22, 0, 3'd0); step();
      chk("addu2_en", {31'd0, wr_en}, 32'd1);
      chk("addu2_addr", {27'd0, wr_addr}, 32'd4);
      chk("addu2_data", wr_data, 32'h22);

      // LB / LBU at offset 1
      drive(1, 1, 5'd5, 32'h0000_1001, 1, 3'b000); step();
      drive(0, 0, 5'd0, 32'h0, 0, 3'd0); rsp(1, 32'h12F4_5678); step(); rsp(0, 0);
      chk("lb_data", wr_data, 32'hFFFF_FFF4);
      chk("lb_en", {31'd0, wr_en}, 32'd1);
      drive(1, 1, 5'd5, 32'h0000_1001, 1, 3'b100); step();
      drive(0, 0, 5'd0, 32'h0, 0, 3'd0); rsp(1, 32'h12F4_5678); step(); rsp(0, 0);
      chk("lbu_data", wr_data, 32'h0000_00F4);

      // LH at offset 2, then misaligned LH
      drive(1, 1, 5'd6, 32'h0000_2002, 1, 3'b001); step();
      drive(0, 0, 5'd0, 32'h0, 0, 3'd0); rsp(1, 32'h0000_8001); step(); rsp(0, 0);
      chk("lh_data", wr_data, 32'hFFFF_8001);
      drive(1, 1, 5'd6, 32'h0000_2001, 1, 3'b001); step();
      drive(0, 0, 5'd0, 32'h0, 0, 3'd0);
      chk("lh_mis_aerr", {31'd0, align_err}, 32'd1);
      chk("lh_mis_en", {31'd0, wr_en}, 32'd0);
      chk("lh_mis_ready", {31'd0, mem_ready}, 32'd1);

      // LW timeout
      drive(1, 1, 5'd7, 32'h0000_0100, 1, 3'b010); step();
      drive(0, 0, 5'd0, 32'h0, 0, 3'd0);
      busy_n = wb_busy ? 1 : 0;
      for (int i = 0; i < MW; i++) begin
         step();
         if (wb_busy) busy_n++;
      end
      chk("to_busy_cycles", busy_n, MW);
      chk("to_lerr", {31'd0, load_err}, 32'd1);
      chk("to_en", {31'd0, wr_en}, 32'd0);
      chk("to_ready", {31'd0, mem_ready}, 32'd1);

      // rvalid on the last allowed cycle
      drive(1, 1, 5'd8, 32'h0000_0200, 1, 3'b010); step();
      drive(0, 0, 5'd0, 32'h0, 0, 3'd0);
      for (int i = 0; i < MW - 1; i++) step();
      rsp(1, 32'hCAFE_F00D); step(); rsp(0, 0);
      chk("late_en", {31'd0, wr_en}, 32'd1);
      chk("late_data", wr_data, 32'hCAFE_F00D);
      chk("late_lerr", {31'd0, load_err}, 32'd0);

      // Write to r0
      drive(1, 1, 5'd0, 32'h55, 0, 3'd0); step();
      chk("r0_en", {31'd0, wr_en}, 32'd0);

      // Flush, then late rvalid
      drive(1, 1, 5'd9, 32'h0000_0300, 1, 3'b010); step();
      drive(0, 0, 5'd0, 32'h0, 0, 3'd0); step();
      flush = 1; step(); flush = 0;
      rsp(1, 32'h1234_5678); step(); rsp(0, 0);
      chk("flush_en", {31'd0, wr_en}, 32'd0);
      chk("flush_busy", {31'd0, wb_busy}, 32'd0);

      // Reset during WAIT_LOAD
      drive(1, 1, 5'd10, 32'h0000_0400, 1, 3'b010); step();
      drive(0, 0, 5'd0, 32'h0, 0, 3'd0); step();
      reset = 1; step(); reset = 0;
      chk("rstld_en", {31'd0, wr_en}, 32'd0);
      chk("rstld_busy", {31'd0, wb_busy}, 32'd0);
      chk("rstld_data", wr_data, 32'd0);
      rsp(1, 32'h8765_4321); step(); rsp(0, 0);
      chk("rstld_stray", {31'd0, wr_en}, 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if (!(mem_valid && !e_ready)) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, 5'($urandom),
                  $urandom, $urandom_range(0, 9) < 4, lt_tab[$urandom_range(0, 7)]);
         end
         rsp($urandom_range(0, 11) == 0, $urandom);
         flush = ($urandom_range(0, 29) == 0);
         reset = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
